// File: rtl/dds_wave_shaper.sv
// dds_wave_shaper
//   Phase-to-amplitude converter for the DDS chain. Turns the phase
//   accumulator output into an unsigned offset-binary sample, one sample per
//   clock, through a fixed three-register pipeline:
//     S1  phase + offset, quadrant mirror of the sine table address
//     S2  synchronous quarter-wave sine table read
//     S3  waveform select into the output register
//   Mode and offset are captured with each sample, so waveform changes take
//   effect on a sample boundary.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low
//   in_valid      phase_in / phase_offset / mode carry a sample this cycle
//   phase_in      accumulator phase (PHASE_W)
//   phase_offset  phase offset, added modulo 2^PHASE_W (PHASE_W)
//   mode          0 triangle, 1 sine, 2 sawtooth, 3 square
//   amp_out       amplitude, offset binary, midscale 2^(AMP_W-1) (AMP_W)
//   out_valid     amp_out carries a new sample this cycle
//
// INIT_FILE names the reference image of the quarter-wave table. The table
// itself is computed at elaboration with the same definition
// (round((M-1)*sin(pi/2*(k+0.5)/2^ADDR_W))), so builds need no data file.

module dds_wave_shaper #(
  parameter int PHASE_W   = 10,
  parameter int ADDR_W    = 8,
  parameter int AMP_W     = 10,
  parameter     INIT_FILE = "sine_quarter.hex"
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic [1:0]         mode,
  output logic [AMP_W-1:0]   amp_out,
  output logic               out_valid
);

  localparam int LUT_N    = 1 << ADDR_W;
  localparam int LUT_W    = AMP_W - 1;
  localparam int FOLD_W   = PHASE_W - 1;
  localparam int AMP_PEAK = (1 << (AMP_W - 1)) - 1;

  localparam logic [AMP_W-1:0] MID = {1'b1, {(AMP_W-1){1'b0}}};

  // Q60 fixed point: 1.0 and pi (pi = 3.243F6A8885A308D3... in hex).
  localparam logic [127:0] ONE_Q60 = 128'd1 << 60;
  localparam logic [127:0] PI_Q60  = 128'h3243F6A8885A308D;

  typedef enum logic [1:0] {
    WAVE_TRI  = 2'd0,
    WAVE_SINE = 2'd1,
    WAVE_SAW  = 2'd2,
    WAVE_SQR  = 2'd3
  } wave_e;

  // Table entry k, evaluated at elaboration. sin(x) by Horner-form Taylor
  // series to x^19, far below one LSB of error over [0, pi/2).
  function automatic logic [LUT_W-1:0] sine_entry(input int k);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] r;
    logic [127:0] term;
    logic [127:0] s;
    x  = (PI_Q60 * 128'(2 * k + 1)) >> (ADDR_W + 2);
    x2 = (x * x) >> 60;
    r  = ONE_Q60;
    for (int n = 9; n >= 1; n--) begin
      term = ((x2 * r) >> 60) / 128'(2 * n * (2 * n + 1));
      r    = ONE_Q60 - term;
    end
    s = (x * r) >> 60;
    return LUT_W'((s * 128'(AMP_PEAK) + (ONE_Q60 >> 1)) >> 60);
  endfunction

  logic [LUT_W-1:0] lut_rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic [LUT_W-1:0] ENTRY = sine_entry(k);
    assign lut_rom[k] = ENTRY;
  end

  // ---------------------------------------------------------------- S1
  logic [PHASE_W-1:0] p_sum;
  logic [ADDR_W-1:0]  a_raw;

  logic               s1_valid;
  logic [PHASE_W-1:0] s1_p;
  logic [ADDR_W-1:0]  s1_a;
  wave_e              s1_mode;

  assign p_sum = phase_in + phase_offset;
  assign a_raw = p_sum[PHASE_W-3 -: ADDR_W];

  // Odd quadrants walk the quarter table backwards. The quadrant itself is
  // the top two bits of p, which travel down the pipe inside p.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_a     <= '0;
      s1_mode  <= WAVE_TRI;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p    <= p_sum;
        s1_a    <= p_sum[PHASE_W-2] ? ~a_raw : a_raw;
        s1_mode <= wave_e'(mode);
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic               s2_valid;
  logic [PHASE_W-1:0] s2_p;
  logic [LUT_W-1:0]   s2_lut;
  wave_e              s2_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_lut   <= '0;
      s2_mode  <= WAVE_TRI;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p    <= s1_p;
        s2_lut  <= lut_rom[s1_a];
        s2_mode <= s1_mode;
      end
    end
  end

  // ---------------------------------------------------------------- S3
  logic [FOLD_W-1:0] tri_fold;
  logic [AMP_W-1:0]  tri_amp;
  logic [AMP_W-1:0]  sine_amp;
  logic [AMP_W-1:0]  amp_next;

  // Triangle: phase below the top bit, mirrored in the second half-period.
  assign tri_fold = s2_p[PHASE_W-1] ? ~s2_p[FOLD_W-1:0] : s2_p[FOLD_W-1:0];

  if (FOLD_W >= AMP_W) begin : g_tri_trunc
    assign tri_amp = tri_fold[FOLD_W-1 -: AMP_W];
  end else begin : g_tri_rep
    // Narrow phase: append the fold's MSBs so the ramp still spans the full
    // 0 .. 2^AMP_W-1 range.
    assign tri_amp = {tri_fold, tri_fold[FOLD_W-1 -: (AMP_W - FOLD_W)]};
  end

  // L <= M-1, so M+L and M-L stay within 1 .. 2^AMP_W-1.
  assign sine_amp = s2_p[PHASE_W-1] ? (MID - {1'b0, s2_lut})
                                    : (MID + {1'b0, s2_lut});

  always_comb begin
    amp_next = MID;
    unique case (s2_mode)
      WAVE_TRI:  amp_next = tri_amp;
      WAVE_SINE: amp_next = sine_amp;
      WAVE_SAW:  amp_next = s2_p[PHASE_W-1 -: AMP_W];
      WAVE_SQR:  amp_next = s2_p[PHASE_W-1] ? '0 : '1;
      default:   amp_next = MID;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      amp_out   <= MID;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        amp_out <= amp_next;
      end
    end
  end

endmodule

// File: tb/tb_dds_wave_shaper.sv
// Bench for dds_wave_shaper at default parameters (10-bit phase, 8-bit
// table address, 10-bit amplitude, midscale 512).

module tb_dds_wave_shaper;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [9:0] phase_in;
  logic [9:0] phase_offset;
  logic [1:0] mode;
  logic [9:0] amp_out;
  logic       out_valid;

  dds_wave_shaper dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .phase_in     (phase_in),
    .phase_offset (phase_offset),
    .mode         (mode),
    .amp_out      (amp_out),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] exp_amp;
    int         due;
    string      name;
  } exp_t;

  typedef struct {
    logic [9:0] phase;
    logic [9:0] offset;
    logic [1:0] md;
    logic [9:0] exp_amp;
    string      name;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [9:0] last_amp = 10'd512;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Reference quarter-wave table straight from its defining formula.
  function automatic int sine_l(input int k);
    real v;
    v = 511.0 * $sin(3.14159265358979323846 * (real'(k) + 0.5) / 512.0);
    return $rtoi(v + 0.5);
  endfunction

  function automatic logic [9:0] model(input logic [9:0] ph, input logic [9:0] off,
                                       input logic [1:0] md);
    logic [9:0] p;
    int f;
    int l;
    p = ph + off;
    case (md)
      2'd0: begin
        // fold is 0..511; scale to 0..1023 by x*2 + (x>>8)
        f = p[9] ? 511 - int'(p[8:0]) : int'(p[8:0]);
        return 10'(f * 2 + (f >> 8));
      end
      2'd1: begin
        l = sine_l(p[8] ? 255 - int'(p[7:0]) : int'(p[7:0]));
        return p[9] ? 10'(512 - l) : 10'(512 + l);
      end
      2'd2: return p;
      default: return p[9] ? 10'd0 : 10'd1023;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output side of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("reset_amp", amp_out, 512);
      chk("reset_valid", out_valid, 0);
      last_amp = 10'd512;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk(e.name, amp_out, e.exp_amp);
        chk({e.name, "_latency"}, cyc, e.due);
      end
      last_amp = amp_out;
    end else begin
      chk("amp_hold", amp_out, last_amp);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk({sb[0].name, "_missing"}, 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  // Input side: drive one sample, push its expectation, advance one clock.
  task automatic send(input logic [9:0] ph, input logic [9:0] off, input logic [1:0] md,
                      input logic [9:0] want, input string name);
    exp_t e;
    in_valid     = 1'b1;
    phase_in     = ph;
    phase_offset = off;
    mode         = md;
    e.exp_amp = want;
    e.due     = cyc + 3;
    e.name    = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [9:0] ph, input logic [9:0] off, input logic [1:0] md,
                       input string name);
    send(ph, off, md, model(ph, off, md), name);
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid     = 1'b0;
      phase_in     = 10'($urandom);
      phase_offset = 10'($urandom);
      mode         = 2'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void add_vec(input logic [9:0] ph, input logic [9:0] off,
                                  input logic [1:0] md, input logic [9:0] want,
                                  input string name);
    vec_t v;
    v.phase   = ph;
    v.offset  = off;
    v.md      = md;
    v.exp_amp = want;
    v.name    = name;
    vecs.push_back(v);
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    add_vec(10'd0,    10'd0,   2'd1, 10'd514,  "sine_p0");
    add_vec(10'd256,  10'd0,   2'd1, 10'd1023, "sine_p256");
    add_vec(10'd512,  10'd0,   2'd1, 10'd510,  "sine_p512");
    add_vec(10'd768,  10'd0,   2'd1, 10'd1,    "sine_p768");
    add_vec(10'd0,    10'd0,   2'd0, 10'd0,    "tri_p0");
    add_vec(10'd511,  10'd0,   2'd0, 10'd1023, "tri_p511");
    add_vec(10'd512,  10'd0,   2'd0, 10'd1023, "tri_p512");
    add_vec(10'd1023, 10'd0,   2'd0, 10'd0,    "tri_p1023");
    add_vec(10'd300,  10'd0,   2'd2, 10'd300,  "saw_p300");
    add_vec(10'd100,  10'd0,   2'd3, 10'd1023, "sqr_p100");
    add_vec(10'd600,  10'd0,   2'd3, 10'd0,    "sqr_p600");
    add_vec(10'd1000, 10'd100, 2'd2, 10'd76,   "offset_wrap");
    add_vec(10'd200,  10'd56,  2'd1, 10'd1023, "sine_offset");

    reset        = 1'b0;
    in_valid     = 1'b0;
    phase_in     = '0;
    phase_offset = '0;
    mode         = '0;
    repeat (2) @(posedge clk);
    #1;

    // Stimulus while held in reset must not disturb the outputs.
    for (int i = 0; i < 5; i++) begin
      in_valid     = 1'b1;
      phase_in     = 10'($urandom);
      phase_offset = 10'($urandom);
      mode         = 2'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    bubble(2);

    send(10'd256, 10'd0, 2'd1, 10'd1023, "first_after_reset");
    bubble(4);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].phase, vecs[i].offset, vecs[i].md, vecs[i].exp_amp, vecs[i].name);
    end
    bubble(4);

    // Per-sample mode, back to back.
    send(10'd256, 10'd0, 2'd1, 10'd1023, "mode_sw_a1");
    send(10'd256, 10'd0, 2'd3, 10'd1023, "mode_sw_a2");
    bubble(3);
    send(10'd256, 10'd0, 2'd1, 10'd1023, "mode_sw_b1");
    send(10'd768, 10'd0, 2'd3, 10'd0,    "mode_sw_b2");
    bubble(3);

    // Bubble pattern 1,0,1,1.
    sendm(10'd100, 10'd0, 2'd1, "bub_1");
    bubble(1);
    sendm(10'd700, 10'd0, 2'd1, "bub_3");
    sendm(10'd900, 10'd0, 2'd2, "bub_4");
    bubble(3);

    // Wrap from 1023 to 0 in each mode.
    for (int m = 0; m < 4; m++) begin
      sendm(10'd1023, 10'd0, 2'(m), "wrap_hi");
      sendm(10'd0,    10'd0, 2'(m), "wrap_lo");
    end
    sendm(10'd1020, 10'd10, 2'd1, "wrap_offset_sine");

    for (int i = 0; i < 1024; i++) sendm(10'(i), 10'd0, 2'd1, "sine_sweep");
    for (int i = 0; i < 256; i++) sendm(10'(i * 4 + 3), 10'(i), 2'd0, "tri_sweep");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) bubble(1);
      else sendm(10'($urandom), 10'($urandom), 2'($urandom), "rand");
    end
    bubble(5);

    // Reset with three samples in flight.
    sendm(10'd256, 10'd0, 2'd1, "flush_a");
    sendm(10'd300, 10'd0, 2'd2, "flush_b");
    sendm(10'd100, 10'd0, 2'd3, "flush_c");
    reset = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_amp", amp_out, 512);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("rst_flush", seen, 0);

    sendm(10'd512, 10'd0, 2'd1, "after_mid_reset");
    bubble(6);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
